// File: rtl/alu.sv
// =============================================================================
// Module   : alu
// Summary  : 8-bit, 16-operation ALU with registered result and carry/zero
//            flags. Define ALU_NEG_OVF_FLAGS_EN to add flag_neg/flag_ovf.
// Revision : 1.0  initial release
// =============================================================================
`default_nettype none

module alu #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic [3:0]       mode,
   input  logic             ee,
   input  logic             eo,
   output logic [WIDTH-1:0] out,
   output logic             flag_carry,
   output logic             flag_zero
`ifdef ALU_NEG_OVF_FLAGS_EN
   ,
   output logic             flag_neg,
   output logic             flag_ovf
`endif
);

   localparam int         c_HALF = WIDTH / 2;

   localparam logic [3:0] c_ADD  = 4'b0000;
   localparam logic [3:0] c_SUB  = 4'b0001;
   localparam logic [3:0] c_AND  = 4'b0010;
   localparam logic [3:0] c_OR   = 4'b0011;
   localparam logic [3:0] c_XOR  = 4'b0100;
   localparam logic [3:0] c_NOT  = 4'b0101;
   localparam logic [3:0] c_INC  = 4'b0110;
   localparam logic [3:0] c_DEC  = 4'b0111;
   localparam logic [3:0] c_SHL  = 4'b1000;
   localparam logic [3:0] c_SHR  = 4'b1001;
   localparam logic [3:0] c_ROL  = 4'b1010;
   localparam logic [3:0] c_ROR  = 4'b1011;
   localparam logic [3:0] c_CMP  = 4'b1100;
   localparam logic [3:0] c_MLO  = 4'b1101;
   localparam logic [3:0] c_MHI  = 4'b1110;
   localparam logic [3:0] c_SQRT = 4'b1111;

   localparam logic [WIDTH-1:0] c_ONE = {{(WIDTH-1){1'b0}}, 1'b1};
   localparam logic [WIDTH-1:0] c_ALL = {WIDTH{1'b1}};

   logic [WIDTH-1:0]   r_result;
   logic [WIDTH:0]     w_sum;
   logic [WIDTH:0]     w_diff;
   logic [2*WIDTH-1:0] w_prod;
   logic               w_prod_hi_nz;
   logic [c_HALF-1:0]  w_root;
   logic [c_HALF-1:0]  w_trial;
   logic [WIDTH-1:0]   w_trial_sq;
   logic [WIDTH-1:0]   w_root_sq;
   logic [WIDTH-1:0]   w_res;
   logic               w_carry;
   logic               w_zero;
`ifdef ALU_NEG_OVF_FLAGS_EN
   logic               w_ovf;
`endif

   assign w_sum        = {1'b0, in_a} + {1'b0, in_b};
   assign w_diff       = {1'b0, in_a} - {1'b0, in_b};
   assign w_prod       = {{WIDTH{1'b0}}, in_a} * {{WIDTH{1'b0}}, in_b};
   assign w_prod_hi_nz = (w_prod[2*WIDTH-1:WIDTH] != '0);

   // Restoring square root: try each root bit from MSB down, keep it if the
   // trial square still fits under in_a.
   always_comb begin
      w_root     = '0;
      w_trial    = '0;
      w_trial_sq = '0;
      for (int i = c_HALF - 1; i >= 0; i--) begin
         w_trial    = w_root;
         w_trial[i] = 1'b1;
         w_trial_sq = {{c_HALF{1'b0}}, w_trial} * {{c_HALF{1'b0}}, w_trial};
         if (w_trial_sq <= in_a) begin
            w_root = w_trial;
         end
      end
      w_root_sq = {{c_HALF{1'b0}}, w_root} * {{c_HALF{1'b0}}, w_root};
   end

   always_comb begin
      w_res   = '0;
      w_carry = 1'b0;
      case (mode)
         c_ADD:  begin w_res = w_sum[WIDTH-1:0];  w_carry = w_sum[WIDTH];  end
         c_SUB:  begin w_res = w_diff[WIDTH-1:0]; w_carry = w_diff[WIDTH]; end
         c_AND:  w_res = in_a & in_b;
         c_OR:   w_res = in_a | in_b;
         c_XOR:  w_res = in_a ^ in_b;
         c_NOT:  w_res = ~in_a;
         c_INC:  begin w_res = in_a + c_ONE; w_carry = (in_a == c_ALL); end
         c_DEC:  begin w_res = in_a - c_ONE; w_carry = (in_a == '0);    end
         c_SHL:  begin w_res = {in_a[WIDTH-2:0], 1'b0};        w_carry = in_a[WIDTH-1]; end
         c_SHR:  begin w_res = {1'b0, in_a[WIDTH-1:1]};        w_carry = in_a[0];       end
         c_ROL:  begin w_res = {in_a[WIDTH-2:0], in_a[WIDTH-1]}; w_carry = in_a[WIDTH-1]; end
         c_ROR:  begin w_res = {in_a[0], in_a[WIDTH-1:1]};     w_carry = in_a[0];       end
         c_CMP:  begin w_res = in_a; w_carry = w_diff[WIDTH]; end
         c_MLO:  begin w_res = w_prod[WIDTH-1:0];       w_carry = w_prod_hi_nz; end
         c_MHI:  begin w_res = w_prod[2*WIDTH-1:WIDTH]; w_carry = w_prod_hi_nz; end
         c_SQRT: begin
            w_res   = {{(WIDTH-c_HALF){1'b0}}, w_root};
            w_carry = (w_root_sq != in_a);
         end
         default: begin w_res = '0; w_carry = 1'b0; end
      endcase
      // CMP reports equality rather than a zero result
      w_zero = (mode == c_CMP) ? (in_a == in_b) : (w_res == '0);
   end

`ifdef ALU_NEG_OVF_FLAGS_EN
   always_comb begin
      w_ovf = 1'b0;
      case (mode)
         c_ADD:   w_ovf = (in_a[WIDTH-1] == in_b[WIDTH-1]) && (w_res[WIDTH-1] != in_a[WIDTH-1]);
         c_SUB:   w_ovf = (in_a[WIDTH-1] != in_b[WIDTH-1]) && (w_res[WIDTH-1] != in_a[WIDTH-1]);
         c_INC:   w_ovf = (in_a == {1'b0, {(WIDTH-1){1'b1}}});
         c_DEC:   w_ovf = (in_a == {1'b1, {(WIDTH-1){1'b0}}});
         default: w_ovf = 1'b0;
      endcase
   end
`endif

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_result   <= '0;
         flag_carry <= 1'b0;
         flag_zero  <= 1'b0;
`ifdef ALU_NEG_OVF_FLAGS_EN
         flag_neg   <= 1'b0;
         flag_ovf   <= 1'b0;
`endif
      end else if (ee) begin
         r_result   <= w_res;
         flag_carry <= w_carry;
         flag_zero  <= w_zero;
`ifdef ALU_NEG_OVF_FLAGS_EN
         flag_neg   <= w_res[WIDTH-1];
         flag_ovf   <= w_ovf;
`endif
      end
   end

   assign out = eo ? r_result : '0;

endmodule

`default_nettype wire

// File: tb/tb_alu.sv
// =============================================================================
// Module   : tb_alu
// Summary  : Directed-vector self-checking bench for alu.
// Revision : 1.0  initial release
// =============================================================================
`default_nettype none

module tb_alu;

   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] in_a;
   logic [7:0] in_b;
   logic [3:0] mode;
   logic       ee;
   logic       eo;
   logic [7:0] out;
   logic       flag_carry;
   logic       flag_zero;
`ifdef ALU_NEG_OVF_FLAGS_EN
   logic       flag_neg;
   logic       flag_ovf;
`endif

   int n_vec = 0;
   int n_err = 0;

   alu #(.WIDTH(8)) u_dut (
      .clk        (clk),
      .reset      (reset),
      .in_a       (in_a),
      .in_b       (in_b),
      .mode       (mode),
      .ee         (ee),
      .eo         (eo),
      .out        (out),
      .flag_carry (flag_carry),
      .flag_zero  (flag_zero)
`ifdef ALU_NEG_OVF_FLAGS_EN
      ,
      .flag_neg   (flag_neg),
      .flag_ovf   (flag_ovf)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
      n_vec++;
      if (obs !== exp_v) begin
         n_err++;
         $display("FAIL %s: got %02h expected %02h", tag, obs, exp_v);
      end
   endtask

   task automatic check3(input string tag, input logic [7:0] e_out,
                         input logic e_c, input logic e_z);
      check({tag, ".out"},   out,                    e_out);
      check({tag, ".carry"}, {7'd0, flag_carry},     {7'd0, e_c});
      check({tag, ".zero"},  {7'd0, flag_zero},      {7'd0, e_z});
   endtask

   // Apply operands, take one edge, sample 1 ns later.
   task automatic op(input logic [7:0] a, input logic [7:0] b, input logic [3:0] m);
      in_a = a;
      in_b = b;
      mode = m;
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset = 1'b0; ee = 1'b1; eo = 1'b1;
      op(8'hFF, 8'h01, 4'b0000);
      check3("reset", 8'h00, 1'b0, 1'b0);

      reset = 1'b1; ee = 1'b0;
      op(8'h12, 8'h34, 4'b0011);
      check3("reset_hold", 8'h00, 1'b0, 1'b0);

      ee = 1'b1;
      op(8'h80, 8'h80, 4'b1101); check3("mlo_80x80", 8'h00, 1'b1, 1'b1);
      op(8'h80, 8'h80, 4'b1110); check3("mhi_80x80", 8'h40, 1'b1, 1'b0);
      op(8'h03, 8'h05, 4'b1101); check3("mlo_3x5",   8'h0F, 1'b0, 1'b0);

      op(8'h04, 8'h99, 4'b1111); check3("sqrt_04", 8'h02, 1'b0, 1'b0);
      op(8'h05, 8'h00, 4'b1111); check3("sqrt_05", 8'h02, 1'b1, 1'b0);
      op(8'hFF, 8'h00, 4'b1111); check3("sqrt_ff", 8'h0F, 1'b1, 1'b0);
      op(8'h00, 8'h00, 4'b1111); check3("sqrt_00", 8'h00, 1'b0, 1'b1);
      op(8'hE1, 8'h00, 4'b1111); check3("sqrt_e1", 8'h0F, 1'b0, 1'b0);

      op(8'hFF, 8'h01, 4'b0000); check3("add_wrap", 8'h00, 1'b1, 1'b1);
      op(8'h12, 8'h34, 4'b0000); check3("add",      8'h46, 1'b0, 1'b0);
      op(8'h03, 8'h05, 4'b0001); check3("sub_brw",  8'hFE, 1'b1, 1'b0);
      op(8'h05, 8'h05, 4'b0001); check3("sub_eq",   8'h00, 1'b0, 1'b1);
      op(8'hF0, 8'h3C, 4'b0010); check3("and",      8'h30, 1'b0, 1'b0);
      op(8'hF0, 8'h0F, 4'b0011); check3("or",       8'hFF, 1'b0, 1'b0);
      op(8'hAA, 8'hAA, 4'b0100); check3("xor",      8'h00, 1'b0, 1'b1);
      op(8'h0F, 8'h00, 4'b0101); check3("not",      8'hF0, 1'b0, 1'b0);
      op(8'hFF, 8'h00, 4'b0110); check3("inc_ff",   8'h00, 1'b1, 1'b1);
      op(8'h00, 8'h00, 4'b0111); check3("dec_00",   8'hFF, 1'b1, 1'b0);
      op(8'h80, 8'h00, 4'b1000); check3("shl_80",   8'h00, 1'b1, 1'b1);
      op(8'h01, 8'h00, 4'b1001); check3("shr_01",   8'h00, 1'b1, 1'b1);
      op(8'h81, 8'h00, 4'b1010); check3("rol_81",   8'h03, 1'b1, 1'b0);
      op(8'h01, 8'h00, 4'b1011); check3("ror_01",   8'h80, 1'b1, 1'b0);
      op(8'h42, 8'h42, 4'b1100); check3("cmp_eq",   8'h42, 1'b0, 1'b1);
      op(8'h10, 8'h20, 4'b1100); check3("cmp_lt",   8'h10, 1'b1, 1'b0);
      op(8'h00, 8'h01, 4'b1100); check3("cmp_zero", 8'h00, 1'b1, 1'b0);

`ifdef ALU_NEG_OVF_FLAGS_EN
      op(8'h7F, 8'h01, 4'b0000);
      check("ovf_add.neg", {7'd0, flag_neg}, 8'h01);
      check("ovf_add.ovf", {7'd0, flag_ovf}, 8'h01);
      op(8'h80, 8'h00, 4'b0111);
      check("ovf_dec.ovf", {7'd0, flag_ovf}, 8'h01);
      op(8'h80, 8'h80, 4'b1110);
      check("ovf_mhi.ovf", {7'd0, flag_ovf}, 8'h00);
`endif

      op(8'h80, 8'h80, 4'b1110); check3("gate_load", 8'h40, 1'b1, 1'b0);
      eo = 1'b0;
      #1;
      check("gate_eo0.out", out, 8'h00);
      ee = 1'b0;
      op(8'h01, 8'h01, 4'b0000);
      op(8'h00, 8'h00, 4'b0001);
      check3("gate_ee0", 8'h00, 1'b1, 1'b0);
      eo = 1'b1;
      #1;
      check("gate_eo1.out", out, 8'h40);

      ee = 1'b1; reset = 1'b0;
      op(8'hFF, 8'hFF, 4'b1101);
      check3("reset_prio", 8'h00, 1'b0, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

`default_nettype wire
